// File: rtl/pll_clk_sequencer.sv
// PLL supervisor: pulses PLL reset, qualifies a synchronised lock, enables gated
// outputs in ascending order and releases the downstream reset once all are running.
module pll_clk_sequencer #(
    parameter int                 NUM_CLK          = 7,
    parameter logic [NUM_CLK-1:0] EN_MASK          = 7'b0000101,
    parameter int                 PLL_RST_CYC      = 32,
    parameter int                 LOCK_STABLE_CYC  = 1024,
    parameter int                 LOCK_TIMEOUT_CYC = 65536,
    parameter int                 EN_GAP_CYC       = 16,
    parameter int                 CNT_W            = 8
) (
    input  logic               clkin,
    input  logic               rstn,
    input  logic               pll_lock,
    input  logic               force_relock,
    input  logic               clr_cnt,
    output logic               pll_reset,
    output logic [NUM_CLK-1:0] enclk,
    output logic               sys_rstn_out,
    output logic               ready,
    output logic [CNT_W-1:0]   lock_loss_cnt,
    output logic               timeout_flag,
    output logic [1:0]         state
);

    localparam int MAX_A   = (PLL_RST_CYC > EN_GAP_CYC) ? PLL_RST_CYC : EN_GAP_CYC;
    localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYC) ? MAX_A : LOCK_TIMEOUT_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int SW      = $clog2(LOCK_STABLE_CYC + 1);

    typedef enum logic [1:0] {
        ST_RST_PLL   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_ENABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, lock_s_q;
    logic [CW-1:0]      cyc_cnt_q, cyc_cnt_d;
    logic [SW-1:0]      stable_cnt_q, stable_cnt_d;
    logic [NUM_CLK-1:0] enclk_q, enclk_d;
    logic               pll_reset_q, pll_reset_d;
    logic               sys_rstn_q, sys_rstn_d;
    logic               ready_q, ready_d;
    logic [CNT_W-1:0]   loss_cnt_q, loss_cnt_d;
    logic               timeout_q, timeout_d;

    logic [SW-1:0]      stable_inc;
    logic [NUM_CLK-1:0] pending;
    logic [NUM_CLK-1:0] next_bit;
    logic               loss_evt;
    logic               timeout_evt;

    always_comb begin
        state_d      = state_q;
        cyc_cnt_d    = cyc_cnt_q + CW'(1);
        stable_cnt_d = '0;
        enclk_d      = enclk_q;
        loss_evt     = 1'b0;
        timeout_evt  = 1'b0;
        stable_inc   = stable_cnt_q + SW'(1);
        // Lowest still-disabled masked channel, isolated as a one-hot bit.
        pending      = EN_MASK & ~enclk_q;
        next_bit     = pending & (~pending + NUM_CLK'(1));

        case (state_q)
            ST_RST_PLL: begin
                enclk_d = '0;
                if (force_relock) begin
                    cyc_cnt_d = '0;
                end else if (cyc_cnt_q == CW'(PLL_RST_CYC - 1)) begin
                    state_d   = ST_WAIT_LOCK;
                    cyc_cnt_d = '0;
                end
            end
            ST_WAIT_LOCK: begin
                enclk_d = '0;
                if (force_relock) begin
                    state_d   = ST_RST_PLL;
                    cyc_cnt_d = '0;
                end else if (lock_s_q && stable_inc == SW'(LOCK_STABLE_CYC)) begin
                    state_d   = ST_ENABLE;
                    cyc_cnt_d = '0;
                    enclk_d   = next_bit;
                end else if (cyc_cnt_q == CW'(LOCK_TIMEOUT_CYC - 1)) begin
                    state_d     = ST_RST_PLL;
                    cyc_cnt_d   = '0;
                    timeout_evt = 1'b1;
                end else begin
                    stable_cnt_d = lock_s_q ? stable_inc : '0;
                end
            end
            ST_ENABLE: begin
                if (!lock_s_q || force_relock) begin
                    state_d   = ST_RST_PLL;
                    cyc_cnt_d = '0;
                    enclk_d   = '0;
                    loss_evt  = !lock_s_q;
                end else if (cyc_cnt_q == CW'(EN_GAP_CYC - 1)) begin
                    cyc_cnt_d = '0;
                    if (pending != '0) begin
                        enclk_d = enclk_q | next_bit;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                cyc_cnt_d = '0;
                if (!lock_s_q || force_relock) begin
                    state_d  = ST_RST_PLL;
                    enclk_d  = '0;
                    loss_evt = !lock_s_q;
                end
            end
        endcase

        loss_cnt_d = loss_cnt_q;
        timeout_d  = timeout_q;
        // A clear request beats a same-cycle increment or timeout.
        if (clr_cnt) begin
            loss_cnt_d = '0;
            timeout_d  = 1'b0;
        end else begin
            if (loss_evt && loss_cnt_q != '1) begin
                loss_cnt_d = loss_cnt_q + CNT_W'(1);
            end
            if (timeout_evt) begin
                timeout_d = 1'b1;
            end
        end

        pll_reset_d = (state_d == ST_RST_PLL);
        sys_rstn_d  = (state_d == ST_RUN);
        ready_d     = (state_d == ST_RUN);
    end

    always_ff @(posedge clkin) begin
        if (!rstn) begin
            state_q      <= ST_RST_PLL;
            sync1_q      <= 1'b0;
            lock_s_q     <= 1'b0;
            cyc_cnt_q    <= '0;
            stable_cnt_q <= '0;
            enclk_q      <= '0;
            pll_reset_q  <= 1'b1;
            sys_rstn_q   <= 1'b0;
            ready_q      <= 1'b0;
            loss_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= pll_lock;
            lock_s_q     <= sync1_q;
            cyc_cnt_q    <= cyc_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            enclk_q      <= enclk_d;
            pll_reset_q  <= pll_reset_d;
            sys_rstn_q   <= sys_rstn_d;
            ready_q      <= ready_d;
            loss_cnt_q   <= loss_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign pll_reset     = pll_reset_q;
    assign enclk         = enclk_q;
    assign sys_rstn_out  = sys_rstn_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = loss_cnt_q;
    assign timeout_flag  = timeout_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pll_clk_sequencer.sv
// Directed bench for pll_clk_sequencer: a cycle table for bring-up plus
// hand-written sequences for glitch, timeout, lock loss, relock and mid-sequence reset.
module tb_pll_clk_sequencer;

    logic       clkin = 1'b0;
    logic       rstn = 1'b0;
    logic       pll_lock = 1'b0;
    logic       force_relock = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       pll_reset;
    logic [2:0] enclk;
    logic       sys_rstn_out;
    logic       ready;
    logic [7:0] lock_loss_cnt;
    logic       timeout_flag;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rstn;
        logic       lock;
        logic       frc;
        logic       clr;
        logic       pr;
        logic [2:0] en;
        logic       sys;
        logic       rdy;
        logic [1:0] st;
        logic [7:0] cnt;
        logic       tf;
    } vec_t;

    vec_t vecs[$];

    pll_clk_sequencer #(
        .NUM_CLK         (3),
        .EN_MASK         (3'b101),
        .PLL_RST_CYC     (4),
        .LOCK_STABLE_CYC (8),
        .LOCK_TIMEOUT_CYC(64),
        .EN_GAP_CYC      (4),
        .CNT_W           (8)
    ) dut (
        .clkin        (clkin),
        .rstn         (rstn),
        .pll_lock     (pll_lock),
        .force_relock (force_relock),
        .clr_cnt      (clr_cnt),
        .pll_reset    (pll_reset),
        .enclk        (enclk),
        .sys_rstn_out (sys_rstn_out),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt),
        .timeout_flag (timeout_flag),
        .state        (state)
    );

    always #5 clkin = ~clkin;

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic waitState(input logic [1:0] s, input int budget, input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (state !== s && n < budget);
        checkOutput(name, {30'd0, state}, {30'd0, s});
    endtask

    task automatic addVecs(input int n, input logic r, input logic l, input logic pr,
                           input logic [2:0] en, input logic sys, input logic rdy,
                           input logic [1:0] st);
        vec_t v;
        v.rstn = r;   v.lock = l;  v.frc = 1'b0; v.clr = 1'b0;
        v.pr   = pr;  v.en   = en; v.sys = sys;  v.rdy = rdy;
        v.st   = st;  v.cnt  = 8'd0; v.tf = 1'b0;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Full bring-up from reset, one record per clock edge.
    task automatic applyStimulus(input string tag);
        logic [16:0] act;
        logic [16:0] exp;
        for (int i = 0; i < vecs.size(); i++) begin
            rstn         = vecs[i].rstn;
            pll_lock     = vecs[i].lock;
            force_relock = vecs[i].frc;
            clr_cnt      = vecs[i].clr;
            tick();
            act = {pll_reset, enclk, sys_rstn_out, ready, state, lock_loss_cnt, timeout_flag};
            exp = {vecs[i].pr, vecs[i].en, vecs[i].sys, vecs[i].rdy, vecs[i].st,
                   vecs[i].cnt, vecs[i].tf};
            checkOutput($sformatf("%s_vec%0d", tag, i), {15'd0, act}, {15'd0, exp});
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        addVecs(2, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0);
        addVecs(3, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0);
        addVecs(8, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1);
        addVecs(4, 1'b1, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 2'd2);
        addVecs(4, 1'b1, 1'b1, 1'b0, 3'b101, 1'b0, 1'b0, 2'd2);
        addVecs(2, 1'b1, 1'b1, 1'b0, 3'b101, 1'b1, 1'b1, 2'd3);

        applyStimulus("bringup");

        // Lock loss in RUN: two edges of synchroniser delay, then teardown.
        pll_lock = 1'b0;
        tick();
        checkOutput("loss_e1_ready", {31'd0, ready}, 32'd1);
        tick();
        checkOutput("loss_e2_state", {30'd0, state}, 32'd3);
        tick();
        checkOutput("loss_state", {30'd0, state}, 32'd0);
        checkOutput("loss_enclk", {29'd0, enclk}, 32'd0);
        checkOutput("loss_sys_rstn", {31'd0, sys_rstn_out}, 32'd0);
        checkOutput("loss_ready", {31'd0, ready}, 32'd0);
        checkOutput("loss_cnt1", {24'd0, lock_loss_cnt}, 32'd1);
        checkOutput("loss_pll_reset", {31'd0, pll_reset}, 32'd1);

        // Two-cycle lock glitch at stable count 6 restarts the stable window.
        pll_lock = 1'b1;
        waitState(2'd1, 20, "glitch_wait_entry");
        for (int i = 0; i < 4; i++) tick();
        pll_lock = 1'b0;
        tick();
        tick();
        pll_lock = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        checkOutput("glitch_still_wait", {30'd0, state}, 32'd1);
        tick();
        checkOutput("glitch_enable", {30'd0, state}, 32'd2);
        checkOutput("glitch_enclk", {29'd0, enclk}, 32'd1);
        checkOutput("glitch_no_timeout", {31'd0, timeout_flag}, 32'd0);
        waitState(2'd3, 30, "glitch_run");

        for (int k = 2; k <= 3; k++) begin
            pll_lock = 1'b0;
            waitState(2'd0, 10, "loss_teardown");
            checkOutput($sformatf("loss_cnt%0d", k), {24'd0, lock_loss_cnt}, k);
            pll_lock = 1'b1;
            waitState(2'd3, 60, "relock_run");
        end

        // Forced relock with a simultaneous clear: teardown, counter cleared.
        force_relock = 1'b1;
        clr_cnt      = 1'b1;
        tick();
        force_relock = 1'b0;
        clr_cnt      = 1'b0;
        checkOutput("force_state", {30'd0, state}, 32'd0);
        checkOutput("force_cnt_cleared", {24'd0, lock_loss_cnt}, 32'd0);
        checkOutput("force_enclk", {29'd0, enclk}, 32'd0);
        checkOutput("force_ready", {31'd0, ready}, 32'd0);

        // WAIT_LOCK timeout after 64 cycles, then a fresh 4-cycle PLL reset pulse.
        pll_lock = 1'b0;
        waitState(2'd1, 20, "timeout_wait_entry");
        for (int i = 0; i < 63; i++) tick();
        checkOutput("timeout_pre_state", {30'd0, state}, 32'd1);
        checkOutput("timeout_pre_flag", {31'd0, timeout_flag}, 32'd0);
        tick();
        checkOutput("timeout_state", {30'd0, state}, 32'd0);
        checkOutput("timeout_flag_set", {31'd0, timeout_flag}, 32'd1);
        checkOutput("timeout_cnt", {24'd0, lock_loss_cnt}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            checkOutput($sformatf("timeout_pll_reset%0d", i), {31'd0, pll_reset}, 32'd1);
        end
        tick();
        checkOutput("timeout_rewait", {30'd0, state}, 32'd1);
        checkOutput("timeout_pll_reset_low", {31'd0, pll_reset}, 32'd0);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checkOutput("timeout_flag_cleared", {31'd0, timeout_flag}, 32'd0);

        // Repeated lock losses saturate the counter at 255.
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b1;
            waitState(2'd3, 80, "sat_run");
            pll_lock = 1'b0;
            waitState(2'd0, 10, "sat_teardown");
            checkOutput($sformatf("sat_cnt%0d", i), {24'd0, lock_loss_cnt},
                        (i + 1 > 255) ? 255 : i + 1);
        end

        // Reset asserted mid-ENABLE, then a clean restart.
        pll_lock = 1'b1;
        waitState(2'd2, 80, "midreset_enable");
        checkOutput("midreset_enclk_pre", {29'd0, enclk}, 32'd1);
        rstn = 1'b0;
        tick();
        checkOutput("midreset_state", {30'd0, state}, 32'd0);
        checkOutput("midreset_enclk", {29'd0, enclk}, 32'd0);
        checkOutput("midreset_pll_reset", {31'd0, pll_reset}, 32'd1);
        checkOutput("midreset_cnt", {24'd0, lock_loss_cnt}, 32'd0);
        applyStimulus("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_clk_sequencer.md
Name: pll_clk_sequencer

Overview:
Parametrised PLL supervisor running on the free-running PLL reference clock. It drives PLL reset, filters the asynchronous lock flag and gates up to 7 PLL outputs on in a fixed order with programmable spacing. It releases a downstream system reset only after all outputs are running. On lock loss or a forced relock it tears down cleanly and restarts the PLL, counting lock-loss events. It is instantiated beside each PLL wrapper, driving that wrapper's enclk inputs and consuming its lock output.

Parameters:
NUM_CLK, 7, number of gated outputs (1..7)
EN_MASK, 7'b0000101, bit i=1 means output i is sequenced on; bit i=0 means enclk[i] is held low
PLL_RST_CYC, 32, cycles pll_reset is held high per restart (>=1)
LOCK_STABLE_CYC, 1024, consecutive cycles synced lock must be high (>=1)
LOCK_TIMEOUT_CYC, 65536, cycles allowed in WAIT_LOCK before a PLL restart (> LOCK_STABLE_CYC)
EN_GAP_CYC, 16, cycles between successive enables, and between the last enable and system reset release (>=1)
CNT_W, 8, lock-loss counter width

Ports:
clkin  in  1  reference clock; all logic runs on its rising edge
rstn  in  1  synchronous active-low reset
pll_lock  in  1  PLL lock, asynchronous; 2-flop synchronised to lock_s
force_relock  in  1  single-cycle request to restart the PLL
clr_cnt  in  1  clears lock_loss_cnt
pll_reset  out  1  PLL reset, active high
enclk  out  NUM_CLK  per-output clock enables
sys_rstn_out  out  1  downstream active-low reset
ready  out  1  high only in RUN
lock_loss_cnt  out  CNT_W  saturating count of lock losses
timeout_flag  out  1  sticky; set on any WAIT_LOCK timeout; cleared by clr_cnt
state  out  2  RST_PLL=0, WAIT_LOCK=1, ENABLE=2, RUN=3

Behaviour:
- Reset (rstn=0 at an edge): state=RST_PLL, pll_reset=1, enclk=0, sys_rstn_out=0, ready=0, lock_loss_cnt=0, timeout_flag=0, sync flops=0, all counters=0. All outputs are registered.
- RST_PLL:
  - pll_reset=1 for exactly PLL_RST_CYC cycles.
  - enclk=0, sys_rstn_out=0.
  - Then go to WAIT_LOCK; pll_reset=0 from the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - The stable counter increments while lock_s=1 and clears while lock_s=0.
  - When it reaches LOCK_STABLE_CYC, go to ENABLE.
  - The timeout counter runs from state entry. At LOCK_TIMEOUT_CYC cycles: set timeout_flag, go to RST_PLL. A timeout does not increment lock_loss_cnt.
- ENABLE:
  - Channels with EN_MASK=1 are enabled in ascending index order.
  - The lowest such channel's enclk rises in the first ENABLE cycle. Each subsequent one rises EN_GAP_CYC cycles after the previous. Enabled channels stay high.
  - EN_GAP_CYC cycles after the last enable, go to RUN.
  - Empty mask: ENABLE lasts EN_GAP_CYC cycles with all enclk=0.
- RUN: sys_rstn_out=1 and ready=1 from the first RUN cycle.
- Lock loss (lock_s=0 while in ENABLE or RUN):
  - Next cycle: enclk=0, sys_rstn_out=0, ready=0, state=RST_PLL.
  - lock_loss_cnt increments, saturating at 2^CNT_W-1.
- force_relock:
  - In WAIT_LOCK/ENABLE/RUN: same teardown to RST_PLL, not counted.
  - In RST_PLL: restarts the PLL_RST_CYC count.
  - Simultaneous with lock loss: the lock loss is counted.
- clr_cnt: clears lock_loss_cnt and timeout_flag next cycle. If clr_cnt coincides with an increment, the clear wins (result 0).
- Lock glitch in WAIT_LOCK shorter than the stable window: restarts the stable count only; the timeout counter continues.
- rstn low mid-sequence: immediate return to reset values at that edge, regardless of state.

Test Plan:
Bench parameters: NUM_CLK=3, EN_MASK=3'b101, PLL_RST_CYC=4, LOCK_STABLE_CYC=8, EN_GAP_CYC=4, LOCK_TIMEOUT_CYC=64.
1. Release rstn, hold pll_lock=1 -> pll_reset high for 4 cycles; ENABLE entered after 8 stable synced cycles; enclk goes 000 -> 001, then 4 cycles later 101; enclk[1] never high; 4 cycles later sys_rstn_out=1, ready=1, state=3.
2. In WAIT_LOCK, drop pll_lock for 2 cycles at stable count 6 -> stable count restarts; ENABLE entered 8 cycles after lock_s returns high; no timeout_flag.
3. Hold pll_lock=0 -> WAIT_LOCK times out after 64 cycles; timeout_flag=1; pll_reset re-pulses for 4 cycles; lock_loss_cnt stays 0.
4. In RUN, drop pll_lock -> one cycle after lock_s falls: enclk=000, sys_rstn_out=0, ready=0, state=0, lock_loss_cnt=1. Repeat 300 times with CNT_W=8 -> counter holds 255.
5. In RUN, pulse force_relock together with clr_cnt while lock_loss_cnt=3 -> teardown to RST_PLL; lock_loss_cnt=0.
6. Assert rstn=0 mid-ENABLE with enclk=001 -> next edge: enclk=000, pll_reset=1, state=0; the sequence restarts cleanly after release.
